blob_tracker: RTL

Downstream of the connected-components labeller. Consumes its per-pixel label stream and keeps per-label area and bounding box in a dual-port RAM. At end of frame it scans all labels, selects the largest blob meeting `MIN_AREA`, and reports that blob's bounding box and centre as a one-cycle result for the motion/steering logic.

---
 rtl/blob_pkg.sv | 33 +++
 rtl/blob_stats_ram.sv | 26 ++
 rtl/blob_tracker.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/blob_pkg.sv
// Shared types for the blob tracker: per-label statistics record, FSM states
// and the record update used by the accumulation pipeline.
package blob_pkg;

  typedef struct packed {
    logic [15:0] area;
    logic [10:0] xmin;
    logic [10:0] xmax;
    logic [9:0]  ymin;
    logic [9:0]  ymax;
  } blob_rec_t;

  localparam int unsigned REC_W = $bits(blob_rec_t);

  localparam blob_rec_t BLOB_EMPTY = '{area: 16'd0, xmin: 11'h7FF, xmax: 11'd0,
                                       ymin: 10'h3FF, ymax: 10'd0};

  typedef enum logic [1:0] {CLEAR, ACCUM, SCAN, REPORT} tracker_state_t;

  // Fold one pixel into a record; area saturates instead of wrapping.
  function automatic blob_rec_t blob_update(input blob_rec_t r, input logic [10:0] x,
                                            input logic [9:0] y);
    blob_rec_t n;
    n = r;
    if (r.area != 16'hFFFF) n.area = r.area + 16'd1;
    if (x < r.xmin) n.xmin = x;
    if (x > r.xmax) n.xmax = x;
    if (y < r.ymin) n.ymin = y;
    if (y > r.ymax) n.ymax = y;
    return n;
  endfunction

endpackage

// File: rtl/blob_stats_ram.sv
// Simple dual-port label statistics RAM: one write port, one registered read
// port, read-before-write on an address collision, no reset.
module blob_stats_ram #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10,
  parameter int unsigned DW    = 58
) (
  input  logic          clk_in,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_data_q;

  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/blob_tracker.sv
// Accumulates per-label area and bounding box from a labelled pixel stream and
// reports the largest qualifying blob once per frame.
module blob_tracker #(
  parameter int unsigned HRES       = 320,
  parameter int unsigned VRES       = 180,
  parameter int unsigned MAX_LABELS = 1024,
  parameter int unsigned MIN_AREA   = 10
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [15:0] label_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        valid_in,
  output logic        busy_out,
  output logic        overrun_out,
  output logic        result_valid_out,
  output logic        found_out,
  output logic [15:0] best_label_out,
  output logic [15:0] area_out,
  output logic [10:0] x_min_out,
  output logic [10:0] x_max_out,
  output logic [9:0]  y_min_out,
  output logic [9:0]  y_max_out,
  output logic [10:0] x_center_out,
  output logic [9:0]  y_center_out
);
  import blob_pkg::*;

  localparam int unsigned AW = (MAX_LABELS > 1) ? $clog2(MAX_LABELS) : 1;
  localparam int unsigned CW = AW + 1;

  tracker_state_t state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           p1_vld_q, p1_vld_d, p2_vld_q, p2_vld_d, wp_vld_q, wp_vld_d;
  logic [AW-1:0]  p1_addr_q, p1_addr_d, p2_addr_q, p2_addr_d, wp_addr_q, wp_addr_d;
  logic [10:0]    p1_x_q, p1_x_d;
  logic [9:0]     p1_y_q, p1_y_d;
  blob_rec_t      p2_rec_q, p2_rec_d, wp_rec_q, wp_rec_d;
  logic           eof1_q, eof1_d, eof2_q, eof2_d;
  logic           sv_q, sv_d;
  logic [AW-1:0]  sl_q, sl_d;
  logic           bfound_q, bfound_d;
  logic [AW-1:0]  blabel_q, blabel_d;
  blob_rec_t      brec_q, brec_d;
  logic           busy_q, busy_d, overrun_q, overrun_d, rv_q, rv_d, found_q, found_d;
  logic [15:0]    label_q, label_d, area_q, area_d;
  logic [10:0]    xmin_q, xmin_d, xmax_q, xmax_d, xc_q, xc_d;
  logic [9:0]     ymin_q, ymin_d, ymax_q, ymax_d, yc_q, yc_d;

  logic             wr_en;
  logic [AW-1:0]    wr_addr, rd_addr;
  logic [REC_W-1:0] wr_data, rd_data;
  blob_rec_t        rd_rec, fwd_rec;
  logic             eof_c, drain_c, acc_c, cand_c;

  blob_stats_ram #(.DEPTH(MAX_LABELS), .AW(AW), .DW(REC_W)) u_ram (
    .clk_in  (clk_in),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_comb begin
    rd_rec  = blob_rec_t'(rd_data);
    eof_c   = valid_in && (hcount_in == 11'(HRES - 1)) && (vcount_in == 10'(VRES - 1));
    // Pixels between end-of-frame and SCAN would collide with the scan writes.
    drain_c = eof1_q || eof2_q;
    acc_c   = (state_q == ACCUM) && !drain_c && valid_in && (label_in != 16'd0) &&
              (32'(label_in) < MAX_LABELS);

    // Newest in-flight record wins over older write and over RAM data.
    fwd_rec = rd_rec;
    if (p2_vld_q && (p2_addr_q == p1_addr_q))      fwd_rec = p2_rec_q;
    else if (wp_vld_q && (wp_addr_q == p1_addr_q)) fwd_rec = wp_rec_q;

    p1_vld_d  = acc_c;
    p1_addr_d = label_in[AW-1:0];
    p1_x_d    = hcount_in;
    p1_y_d    = vcount_in;
    p2_vld_d  = p1_vld_q;
    p2_addr_d = p1_addr_q;
    p2_rec_d  = blob_update(fwd_rec, p1_x_q, p1_y_q);
    wp_vld_d  = p2_vld_q;
    wp_addr_d = p2_addr_q;
    wp_rec_d  = p2_rec_q;
    eof1_d    = (state_q == ACCUM) && !drain_c && eof_c;
    eof2_d    = eof1_q;

    rd_addr = (state_q == SCAN) ? cnt_q[AW-1:0] : label_in[AW-1:0];
    wr_en   = 1'b0;
    wr_addr = p2_addr_q;
    wr_data = p2_rec_q;
    if ((state_q == CLEAR || state_q == SCAN) && (cnt_q < CW'(MAX_LABELS))) begin
      wr_en   = 1'b1;
      wr_addr = cnt_q[AW-1:0];
      wr_data = BLOB_EMPTY;
    end else if (state_q == ACCUM) begin
      wr_en = p2_vld_q;
    end

    sv_d = (state_q == SCAN) && (cnt_q < CW'(MAX_LABELS));
    sl_d = cnt_q[AW-1:0];
    cand_c = sv_q && (sl_q != '0) && (32'(rd_rec.area) >= MIN_AREA) &&
             (rd_rec.area > brec_q.area);
    bfound_d = '0;
    blabel_d = '0;
    brec_d   = '0;
    if (state_q == SCAN) begin
      bfound_d = bfound_q || cand_c;
      blabel_d = cand_c ? sl_q : blabel_q;
      brec_d   = cand_c ? rd_rec : brec_q;
    end

    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(MAX_LABELS)) begin
          state_d = ACCUM;
          cnt_d   = '0;
        end
      end
      ACCUM: begin
        cnt_d = '0;
        if (eof2_q) state_d = SCAN;
      end
      SCAN: begin
        if (cnt_q == CW'(MAX_LABELS)) state_d = REPORT;
        else cnt_d = cnt_q + CW'(1);
      end
      default: begin
        state_d = ACCUM;
        cnt_d   = '0;
      end
    endcase

    busy_d    = (state_d != ACCUM);
    overrun_d = overrun_q || (valid_in && busy_q);
    rv_d      = (state_d == REPORT);
    found_d   = found_q;
    label_d   = label_q;
    area_d    = area_q;
    xmin_d    = xmin_q;
    xmax_d    = xmax_q;
    ymin_d    = ymin_q;
    ymax_d    = ymax_q;
    xc_d      = xc_q;
    yc_d      = yc_q;
    if (state_d == REPORT) begin
      found_d = bfound_d;
      label_d = bfound_d ? 16'(blabel_d) : 16'd0;
      area_d  = bfound_d ? brec_d.area : 16'd0;
      xmin_d  = bfound_d ? brec_d.xmin : 11'd0;
      xmax_d  = bfound_d ? brec_d.xmax : 11'd0;
      ymin_d  = bfound_d ? brec_d.ymin : 10'd0;
      ymax_d  = bfound_d ? brec_d.ymax : 10'd0;
      xc_d    = bfound_d ? 11'((12'(brec_d.xmin) + 12'(brec_d.xmax)) >> 1) : 11'd0;
      yc_d    = bfound_d ? 10'((11'(brec_d.ymin) + 11'(brec_d.ymax)) >> 1) : 10'd0;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= CLEAR;     cnt_q     <= '0;
      p1_vld_q <= 1'b0;      p1_addr_q <= '0;   p1_x_q <= '0;  p1_y_q <= '0;
      p2_vld_q <= 1'b0;      p2_addr_q <= '0;   p2_rec_q <= '0;
      wp_vld_q <= 1'b0;      wp_addr_q <= '0;   wp_rec_q <= '0;
      eof1_q   <= 1'b0;      eof2_q    <= 1'b0;
      sv_q     <= 1'b0;      sl_q      <= '0;
      bfound_q <= 1'b0;      blabel_q  <= '0;   brec_q <= '0;
      busy_q   <= 1'b0;      overrun_q <= 1'b0; rv_q <= 1'b0;  found_q <= 1'b0;
      label_q  <= '0;        area_q    <= '0;
      xmin_q   <= '0;        xmax_q    <= '0;   ymin_q <= '0;  ymax_q <= '0;
      xc_q     <= '0;        yc_q      <= '0;
    end else begin
      state_q  <= state_d;   cnt_q     <= cnt_d;
      p1_vld_q <= p1_vld_d;  p1_addr_q <= p1_addr_d; p1_x_q <= p1_x_d; p1_y_q <= p1_y_d;
      p2_vld_q <= p2_vld_d;  p2_addr_q <= p2_addr_d; p2_rec_q <= p2_rec_d;
      wp_vld_q <= wp_vld_d;  wp_addr_q <= wp_addr_d; wp_rec_q <= wp_rec_d;
      eof1_q   <= eof1_d;    eof2_q    <= eof2_d;
      sv_q     <= sv_d;      sl_q      <= sl_d;
      bfound_q <= bfound_d;  blabel_q  <= blabel_d;  brec_q <= brec_d;
      busy_q   <= busy_d;    overrun_q <= overrun_d; rv_q <= rv_d;  found_q <= found_d;
      label_q  <= label_d;   area_q    <= area_d;
      xmin_q   <= xmin_d;    xmax_q    <= xmax_d;    ymin_q <= ymin_d; ymax_q <= ymax_d;
      xc_q     <= xc_d;      yc_q      <= yc_d;
    end
  end

  assign busy_out         = busy_q;
  assign overrun_out      = overrun_q;
  assign result_valid_out = rv_q;
  assign found_out        = found_q;
  assign best_label_out   = label_q;
  assign area_out         = area_q;
  assign x_min_out        = xmin_q;
  assign x_max_out        = xmax_q;
  assign y_min_out        = ymin_q;
  assign y_max_out        = ymax_q;
  assign x_center_out     = xc_q;
  assign y_center_out     = yc_q;

endmodule
